// File: rtl/trg_event_buffer.sv
// Trigger event buffer: edge-captures tag/event number/timestamp into a show-ahead FIFO.
// Optional timestamp counter enabled by defining TRG_TIMESTAMP_EN.
module trg_event_buffer #(
    parameter int FIFO_AW      = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic               clk_in,
    input  logic               rst_in_N,
    input  logic               coincid_trg_in,
    input  logic [4:0]         coincid_tag_in,
    input  logic               trg_en_in,
    input  logic               ts_clr_in,
    input  logic               evt_rd_in,
    output logic               evt_valid_out,
    output logic [52:0]        evt_data_out,
    output logic [FIFO_AW:0]   fifo_level_out,
    output logic               fifo_full_out,
    output logic               trg_busy_out,
    output logic [15:0]        evt_lost_cnt_out
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = 53;

    typedef logic [FIFO_AW:0] ptr_t;

    localparam ptr_t DEPTH_LVL = ptr_t'(DEPTH);
    localparam ptr_t AFULL_LVL = ptr_t'(DEPTH - AFULL_MARGIN);

    logic          trg_prev;
    logic          trg_hit;
    logic [15:0]   evt_num;
    logic [31:0]   ts;
    logic [15:0]   lost_cnt;

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    ptr_t          wr_ptr_nxt;
    ptr_t          rd_ptr_nxt;
    ptr_t          level_nxt;

    logic          do_pop;
    logic          do_push;
    logic          do_drop;
    logic [DW-1:0] entry;
    logic [DW-1:0] mem [DEPTH];

    assign trg_hit = coincid_trg_in & ~trg_prev & trg_en_in;
    assign do_pop  = evt_rd_in & evt_valid_out;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = trg_hit & (~fifo_full_out | do_pop);
    assign do_drop = trg_hit & fifo_full_out & ~do_pop;

    assign entry = {evt_num, coincid_tag_in, ts};

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (do_push) begin
            wr_ptr_nxt = wr_ptr + ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_nxt = rd_ptr + ptr_t'(1);
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

`ifdef TRG_TIMESTAMP_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in_N) begin
            ts <= '0;
        end else if (ts_clr_in) begin
            ts <= '0;
        end else begin
            ts <= ts + 32'd1;
        end
    end
`else
    assign ts = '0;
`endif

    // trg_prev resets high so a level held through reset is not an edge.
    always_ff @(posedge clk_in) begin
        if (!rst_in_N) begin
            trg_prev <= 1'b1;
            evt_num  <= '0;
            lost_cnt <= '0;
        end else begin
            trg_prev <= coincid_trg_in;
            if (ts_clr_in) begin
                evt_num  <= '0;
                lost_cnt <= '0;
            end else begin
                if (trg_hit) begin
                    evt_num <= evt_num + 16'd1;
                end
                if (do_drop && lost_cnt != 16'hFFFF) begin
                    lost_cnt <= lost_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_N) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level_out <= '0;
            evt_valid_out  <= 1'b0;
            fifo_full_out  <= 1'b0;
            trg_busy_out   <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            fifo_level_out <= level_nxt;
            evt_valid_out  <= level_nxt != '0;
            fifo_full_out  <= level_nxt == DEPTH_LVL;
            trg_busy_out   <= level_nxt >= AFULL_LVL;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= entry;
        end
    end

    assign evt_data_out     = evt_valid_out ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
    assign evt_lost_cnt_out = lost_cnt;

endmodule

// File: tb/tb_trg_event_buffer.sv
// Directed bench for trg_event_buffer with a queue scoreboard of expected entries.
module tb_trg_event_buffer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in_N;
    logic        coincid_trg_in;
    logic [4:0]  coincid_tag_in;
    logic        trg_en_in;
    logic        ts_clr_in;
    logic        evt_rd_in;
    logic        evt_valid_out;
    logic [52:0] evt_data_out;
    logic [AW:0] fifo_level_out;
    logic        fifo_full_out;
    logic        trg_busy_out;
    logic [15:0] evt_lost_cnt_out;

    always #10 clk_in = ~clk_in;

    trg_event_buffer #(
        .FIFO_AW(AW),
        .AFULL_MARGIN(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in_N(rst_in_N),
        .coincid_trg_in(coincid_trg_in),
        .coincid_tag_in(coincid_tag_in),
        .trg_en_in(trg_en_in),
        .ts_clr_in(ts_clr_in),
        .evt_rd_in(evt_rd_in),
        .evt_valid_out(evt_valid_out),
        .evt_data_out(evt_data_out),
        .fifo_level_out(fifo_level_out),
        .fifo_full_out(fifo_full_out),
        .trg_busy_out(trg_busy_out),
        .evt_lost_cnt_out(evt_lost_cnt_out)
    );

    logic [52:0] sb[$];
    logic        m_prev;
    logic [15:0] m_num;
    logic [15:0] m_lost;
    logic [31:0] m_ts;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        logic [63:0] head;
        chk("level", 64'(fifo_level_out), 64'(sb.size()));
        chk("valid", 64'(evt_valid_out), 64'(sb.size() != 0));
        chk("full", 64'(fifo_full_out), 64'(sb.size() == DEPTH));
        chk("busy", 64'(trg_busy_out), 64'(sb.size() >= DEPTH - 2));
        chk("lost", 64'(evt_lost_cnt_out), 64'(m_lost));
        if (sb.size() != 0) head = 64'(sb[0]);
        else head = 64'd0;
        chk("data", 64'(evt_data_out), head);
    endtask

    // Advance one clock; the model consumes the inputs present at this edge.
    task automatic step();
        logic        hit;
        logic        full_m;
        logic        pop_m;
        logic [31:0] tsf;
        if (!rst_in_N) begin
            m_prev = 1'b1;
            m_num  = '0;
            m_ts   = '0;
            m_lost = '0;
            sb.delete();
        end else begin
            hit    = coincid_trg_in && !m_prev && trg_en_in;
            full_m = sb.size() == DEPTH;
            pop_m  = evt_rd_in && sb.size() != 0;
`ifdef TRG_TIMESTAMP_EN
            tsf = m_ts;
`else
            tsf = 32'd0;
`endif
            if (pop_m) void'(sb.pop_front());
            if (hit) begin
                if (!full_m || pop_m) sb.push_back({m_num, coincid_tag_in, tsf});
                else if (m_lost != 16'hFFFF) m_lost++;
            end
            m_prev = coincid_trg_in;
            if (ts_clr_in) begin
                m_ts   = '0;
                m_num  = '0;
                m_lost = '0;
            end else begin
                m_ts++;
                if (hit) m_num++;
            end
        end
        @(posedge clk_in);
        #1;
        check_status();
    endtask

    task automatic pulse(input logic [4:0] tag, input int gap);
        coincid_trg_in = 1'b1;
        coincid_tag_in = tag;
        step();
        coincid_trg_in = 1'b0;
        coincid_tag_in = 5'd0;
        repeat (gap - 1) step();
    endtask

    logic [4:0]  tags [3];
    logic [31:0] tsv  [3];

    initial begin
        tags[0] = 5'h03;
        tags[1] = 5'h11;
        tags[2] = 5'h1F;
        rst_in_N       = 1'b0;
        coincid_trg_in = 1'b1;
        coincid_tag_in = 5'h07;
        trg_en_in      = 1'b1;
        ts_clr_in      = 1'b0;
        evt_rd_in      = 1'b0;
        repeat (3) step();
        chk("rst_level", 64'(fifo_level_out), 64'd0);
        chk("rst_data", 64'(evt_data_out), 64'd0);

        // level held high through reset release
        rst_in_N = 1'b1;
        repeat (10) step();
        chk("held_valid", 64'(evt_valid_out), 64'd0);
        coincid_trg_in = 1'b0;
        step();

        for (int i = 0; i < 3; i++) pulse(tags[i], 4);
        chk("three_level", 64'(fifo_level_out), 64'd3);
        evt_rd_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("three_num", 64'(evt_data_out[52:37]), 64'(i));
            chk("three_tag", 64'(evt_data_out[36:32]), 64'(tags[i]));
            tsv[i] = evt_data_out[31:0];
            step();
        end
        evt_rd_in = 1'b0;
`ifdef TRG_TIMESTAMP_EN
        chk("ts_diff0", 64'(tsv[1] - tsv[0]), 64'd4);
        chk("ts_diff1", 64'(tsv[2] - tsv[1]), 64'd4);
`else
        chk("ts_zero0", 64'(tsv[0]), 64'd0);
        chk("ts_zero1", 64'(tsv[2]), 64'd0);
`endif

        // overflow: 20 pulses, no reads
        ts_clr_in = 1'b1;
        step();
        ts_clr_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pulse(5'(i), 2);
            if (i == 12) chk("busy_13", 64'(trg_busy_out), 64'd0);
            if (i == 13) chk("busy_14", 64'(trg_busy_out), 64'd1);
        end
        chk("ovf_level", 64'(fifo_level_out), 64'd16);
        chk("ovf_full", 64'(fifo_full_out), 64'd1);
        chk("ovf_lost", 64'(evt_lost_cnt_out), 64'd4);
        evt_rd_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("last_num", 64'(evt_data_out[52:37]), 64'd15);
            step();
        end
        evt_rd_in = 1'b0;
        step();
        step();

        // refill, then push and pop together while full
        for (int i = 0; i < 16; i++) pulse(5'(i), 2);
        coincid_trg_in = 1'b1;
        coincid_tag_in = 5'h0A;
        evt_rd_in      = 1'b1;
        step();
        coincid_trg_in = 1'b0;
        coincid_tag_in = 5'd0;
        evt_rd_in      = 1'b0;
        step();
        chk("pp_level", 64'(fifo_level_out), 64'd16);
        chk("pp_lost", 64'(evt_lost_cnt_out), 64'd4);
        evt_rd_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                chk("pp_tail_num", 64'(evt_data_out[52:37]), 64'd36);
                chk("pp_tail_tag", 64'(evt_data_out[36:32]), 64'h0A);
            end
            step();
        end
        step();
        evt_rd_in = 1'b0;

        // clear coinciding with a trigger
        coincid_trg_in = 1'b1;
        coincid_tag_in = 5'h15;
        ts_clr_in      = 1'b1;
        step();
        coincid_trg_in = 1'b0;
        coincid_tag_in = 5'd0;
        ts_clr_in      = 1'b0;
        repeat (3) step();
        pulse(5'h16, 2);
        chk("clr_num", 64'(evt_data_out[52:37]), 64'd37);
        chk("clr_tag", 64'(evt_data_out[36:32]), 64'h15);
        chk("clr_lost", 64'(evt_lost_cnt_out), 64'd0);
        evt_rd_in = 1'b1;
        step();
        evt_rd_in = 1'b0;
        chk("post_num", 64'(evt_data_out[52:37]), 64'd0);
`ifdef TRG_TIMESTAMP_EN
        chk("post_ts", 64'(evt_data_out[31:0] < 32'd10), 64'd1);
`else
        chk("post_ts", 64'(evt_data_out[31:0]), 64'd0);
`endif
        evt_rd_in = 1'b1;
        step();
        evt_rd_in = 1'b0;

        // disabled capture
        trg_en_in = 1'b0;
        for (int i = 0; i < 5; i++) pulse(5'h1E, 2);
        trg_en_in = 1'b1;
        chk("dis_level", 64'(fifo_level_out), 64'd0);
        chk("dis_lost", 64'(evt_lost_cnt_out), 64'd0);
        pulse(5'h02, 2);
        chk("dis_num", 64'(evt_data_out[52:37]), 64'd1);

        // reset mid-operation discards contents
        pulse(5'h04, 2);
        rst_in_N = 1'b0;
        step();
        rst_in_N = 1'b1;
        chk("mid_rst_level", 64'(fifo_level_out), 64'd0);
        chk("mid_rst_valid", 64'(evt_valid_out), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trg_event_buffer.md
# trg_event_buffer

Trigger event buffer directly downstream of the coincidence stage. It detects each rising edge of the coincidence trigger and captures the 5-bit trigger tag, a running event number and a free-running timestamp. These are queued in a show-ahead FIFO that the readout/PMU side drains with a valid/read handshake. The block reports fill level, overflow losses and an almost-full busy that can be fed back as a busy source.

## Interface
Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW entries (16).
- AFULL_MARGIN, 2, trg_busy_out asserts when level ≥ depth − AFULL_MARGIN.

Ports:
- clk_in  in  1  system clock (20 ns).
- rst_in_N  in  1  reset, synchronous, active-low.
- coincid_trg_in  in  1  coincidence trigger, level or pulse, any length ≥1 cycle.
- coincid_tag_in  in  5  trigger tag, valid in the cycle coincid_trg_in first goes high.
- trg_en_in  in  1  capture enable; edges seen while low are ignored (not counted, not lost).
- ts_clr_in  in  1  synchronous clear of timestamp, event number and lost counter.
- evt_rd_in  in  1  pop head entry (acts only when evt_valid_out=1).
- evt_valid_out  out  1  FIFO not empty.
- evt_data_out  out  53  head entry: {evt_num[15:0], tag[4:0], ts[31:0]}.
- fifo_level_out  out  FIFO_AW+1  entries stored (0..16).
- fifo_full_out  out  1  level = depth.
- trg_busy_out  out  1  almost-full.
- evt_lost_cnt_out  out  16  triggers dropped on full; saturates at 16'hFFFF.

## Operation
- Edge detect: trg_prev register; an accepted edge is coincid_trg_in=1 ∧ trg_prev=0 ∧ trg_en_in=1. trg_prev resets to 1, so a level held through reset is not captured.
- Timestamp: 32-bit counter, +1 every cycle, wraps 32'hFFFFFFFF→0.
- Event number: 16-bit counter, +1 on every accepted edge, including dropped ones, so numbering gaps mark losses. Wraps at 16'hFFFF→0.
- Write: on an accepted edge the entry {evt_num current, coincid_tag_in, ts current} is written if not full, or if full and a pop occurs in the same cycle.
- Drop: full and no pop. The entry is discarded and evt_lost_cnt increments, saturating.
- Pop: evt_rd_in ∧ evt_valid_out advances the read pointer. evt_rd_in while empty is ignored.
- Simultaneous push and pop: level is unchanged; this holds at level 0 is impossible since pop requires valid, and holds at full.
- Pointers: FIFO_AW+1 bits with MSB wrap for full/empty; the level is the registered difference.
- ts_clr_in: timestamp, evt_num and lost counter go to 0 at the next edge. FIFO contents are untouched.
- ts_clr_in coinciding with an accepted edge: the captured entry carries the pre-clear values, and evt_num becomes 0, not 1.

## Timing
- Reset (rst_in_N=0 at an edge): FIFO empty, evt_valid_out=0, evt_data_out=0, fifo_level_out=0, fifo_full_out=0, trg_busy_out=0, evt_lost_cnt_out=0, ts=0, evt_num=0.
- Reset asserted mid-operation discards all stored entries within one cycle.
- Latency: if coincid_trg_in is first sampled high at edge k, evt_valid_out rises after edge k (visible in cycle k+1) when the FIFO was empty.
  - The stored ts equals the counter value visible in cycle k.
- evt_data_out updates in the cycle after a pop.
- fifo_level_out, fifo_full_out and trg_busy_out are registered and update in the same cycle as the pointers.
- Minimum trigger spacing: 2 cycles (high then low). Back-to-back edges every 2 cycles are all captured.

## Configuration
- TRG_TIMESTAMP_EN defined: 32-bit timestamp counter is present and captured into evt_data_out[31:0].
- TRG_TIMESTAMP_EN undefined: no timestamp counter; evt_data_out[31:0] is constant 0; ts_clr_in clears only evt_num and the lost counter. Port list is identical in both builds.

## Test plan
- Reset release with coincid_trg_in held high for 10 cycles, trg_en_in=1 → no entry, evt_valid_out=0, evt_num stays 0.
- 3 pulses with tags 5'h03, 5'h11, 5'h1F, 4 cycles apart, no reads → level=3; pops return evt_num 0,1,2, matching tags, ts differences exactly 4.
- 20 pulses with no reads → level=16, fifo_full_out=1, evt_lost_cnt_out=4; trg_busy_out rose when level reached 14; the draining pop returns evt_num 15 last.
- Full FIFO, accepted edge in the same cycle as evt_rd_in → level stays 16, lost count unchanged, new entry appears at the tail.
- ts_clr_in in the same cycle as a trigger → entry holds pre-clear evt_num; the next trigger reads evt_num=0 and a small ts. Without TRG_TIMESTAMP_EN, ts field is 0.
- trg_en_in=0 during 5 pulses → no entries, evt_num and lost count unchanged.
